// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ requesters (clk_9k6 domain).
// Optional tx_busy watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_9k6,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    input  logic                    tx_busy,
    output logic                    enable_transmiter,
    output logic [DATA_W-1:0]       data_to_send,
    output logic                    sched_busy,
    output logic                    err_timeout
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int CAND_W = IDX_W + 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    win_reg, win_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [N_REQ-1:0]    grant_reg, grant_next;
    logic                enable_reg, enable_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                sched_busy_reg, sched_busy_next;
    logic [DATA_W-1:0]   words [N_REQ];
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [CAND_W-1:0]   cand;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_scheduler: unsupported parameter set");
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_words
            assign words[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan offsets from farthest to nearest so the nearest set request after ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_reg;
        cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = {1'b0, ptr_reg} + CAND_W'(i);
            if (cand >= CAND_W'(N_REQ)) cand = cand - CAND_W'(N_REQ);
            if (req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             err_reg, err_next;
`endif

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        win_next     = win_reg;
        gap_cnt_next = gap_cnt_reg;
        grant_next   = '0;
        enable_next  = 1'b0;
        data_next    = data_reg;
`ifdef UART_SCHED_TIMEOUT_EN
        tmo_cnt_next = tmo_cnt_reg;
        err_next     = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (found) begin
                    win_next   = pick;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                grant_next[win_reg] = 1'b1;
                data_next           = words[win_reg];
                ptr_next            = win_reg;
                state_next          = START;
            end
            START: begin
                enable_next = 1'b1;
                state_next  = WAIT_BUSY;
`ifdef UART_SCHED_TIMEOUT_EN
                tmo_cnt_next = '0;
`endif
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                // Transmitter never started: drop the word, pointer already moved past it.
                else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_next     = 1'b1;
                    gap_cnt_next = '0;
                    state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_next = '0;
                    state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
                else gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
            default: state_next = IDLE;
        endcase
        sched_busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_9k6 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= IDX_W'(N_REQ - 1);
            win_reg        <= '0;
            gap_cnt_reg    <= '0;
            grant_reg      <= '0;
            enable_reg     <= 1'b0;
            data_reg       <= '0;
            sched_busy_reg <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            win_reg        <= win_next;
            gap_cnt_reg    <= gap_cnt_next;
            grant_reg      <= grant_next;
            enable_reg     <= enable_next;
            data_reg       <= data_next;
            sched_busy_reg <= sched_busy_next;
`ifdef UART_SCHED_TIMEOUT_EN
            tmo_cnt_reg    <= tmo_cnt_next;
            err_reg        <= err_next;
`endif
        end
    end

    assign grant             = grant_reg;
    assign enable_transmiter = enable_reg;
    assign data_to_send      = data_reg;
    assign sched_busy        = sched_busy_reg;
`ifdef UART_SCHED_TIMEOUT_EN
    assign err_timeout       = err_reg;
`else
    assign err_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, single frame, fairness, wrap, mid-frame reset, watchdog.
// Follows UART_SCHED_TIMEOUT_EN the same way as the design.
module tb_uart_tx_scheduler;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;

    logic                    clk_9k6 = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        grant;
    logic                    tx_busy = 1'b0;
    logic                    enable_transmiter;
    logic [DATA_W-1:0]       data_to_send;
    logic                    sched_busy;
    logic                    err_timeout;

    int vectors = 0;
    int miscompares = 0;
    int tx_len = 4;
    int tx_cnt = 0;
    bit tx_stuck = 1'b0;

    always #5 clk_9k6 = ~clk_9k6;

    uart_tx_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk_9k6(clk_9k6), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
        .tx_busy(tx_busy), .enable_transmiter(enable_transmiter), .data_to_send(data_to_send),
        .sched_busy(sched_busy), .err_timeout(err_timeout)
    );

    // Transmitter model: busy for tx_len cycles after each start pulse.
    always @(posedge clk_9k6) begin
        #2;
        if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) tx_busy = 1'b0;
        end else if (enable_transmiter && !tx_stuck) begin
            tx_busy = 1'b1;
            tx_cnt  = tx_len;
        end
    end

    task automatic set_word(input int idx, input logic [DATA_W-1:0] w);
        req_data[idx*DATA_W +: DATA_W] = w;
    endtask

    task automatic wait_grant(output logic [N_REQ-1:0] g);
        g = '0;
        for (int i = 0; i < 200 && g == '0; i++) begin
            @(negedge clk_9k6);
            g = grant;
        end
        $display("grant %b data %h at %0t", g, data_to_send, $time);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_9k6);
            if (!sched_busy) break;
        end
        @(negedge clk_9k6);
    endtask

    task automatic test_reset();
        logic [N_REQ-1:0] g;
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_word(i, 16'h1111 * 16'(i + 1));
        repeat (3) @(negedge clk_9k6);
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got %b want 0000", grant); end
        vectors++; if (enable_transmiter !== 1'b0) begin miscompares++; $display("FAIL reset_enable got %b want 0", enable_transmiter); end
        vectors++; if (data_to_send !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h want 0000", data_to_send); end
        vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL reset_sched_busy got %b want 0", sched_busy); end
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_timeout); end
        rst_n = 1'b1;
        @(negedge clk_9k6);
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_first_edge_grant got %b want 0000", grant); end
        @(negedge clk_9k6);
        g = grant;
        $display("grant %b data %h at %0t", g, data_to_send, $time);
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL reset_release_grant got %b want 0001", g); end
        vectors++; if (data_to_send !== 16'h1111) begin miscompares++; $display("FAIL reset_release_data got %h want 1111", data_to_send); end
        req = '0;
        wait_idle();
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] g;
        int bad_data = 0;
        int tail = 0;
        tx_len = 10;
        set_word(2, 16'hA5C3);
        req = 4'b0100;
        @(negedge clk_9k6);
        @(negedge clk_9k6);
        g = grant;
        $display("grant %b data %h at %0t", g, data_to_send, $time);
        vectors++; if (g !== 4'b0100) begin miscompares++; $display("FAIL single_grant got %b want 0100", g); end
        vectors++; if (data_to_send !== 16'hA5C3) begin miscompares++; $display("FAIL single_data got %h want a5c3", data_to_send); end
        req = '0;
        @(negedge clk_9k6);
        vectors++; if (enable_transmiter !== 1'b1) begin miscompares++; $display("FAIL single_enable got %b want 1", enable_transmiter); end
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL single_grant_pulse got %b want 0000", grant); end
        @(negedge clk_9k6);
        vectors++; if (enable_transmiter !== 1'b0) begin miscompares++; $display("FAIL single_enable_pulse got %b want 0", enable_transmiter); end
        for (int i = 0; i < 30 && tx_busy; i++) begin
            if (data_to_send !== 16'hA5C3) bad_data++;
            @(negedge clk_9k6);
        end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL single_data_stable got %0d bad cycles want 0", bad_data); end
        for (int i = 0; i < 30 && sched_busy; i++) begin
            tail++;
            @(negedge clk_9k6);
        end
        vectors++; if (tail !== 3) begin miscompares++; $display("FAIL single_gap got %0d busy cycles want 3", tail); end
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] one = 4'b0001;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [DATA_W-1:0] exp_word [4] = '{16'hA05A, 16'hA15A, 16'hA25A, 16'hA35A};
        tx_len = 3;
        @(negedge clk_9k6); rst_n = 1'b0;
        @(negedge clk_9k6); rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_word(i, exp_word[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            vectors++; if (g !== (one << exp_order[k])) begin miscompares++; $display("FAIL fair_grant_%0d got %b want %b", k, g, one << exp_order[k]); end
            vectors++; if (data_to_send !== exp_word[exp_order[k]]) begin miscompares++; $display("FAIL fair_data_%0d got %h want %h", k, data_to_send, exp_word[exp_order[k]]); end
            req[exp_order[k]] = 1'b0;
            @(negedge clk_9k6);
            req[exp_order[k]] = 1'b1;
        end
        req = '0;
        wait_idle();
    endtask

    task automatic test_wrap();
        logic [N_REQ-1:0] g;
        set_word(3, 16'h3E3E);
        set_word(1, 16'h1B1B);
        req = 4'b1000;
        wait_grant(g);
        vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL wrap_setup got %b want 1000", g); end
        req = '0;
        wait_idle();
        req = 4'b1010;
        wait_grant(g);
        vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL wrap_first got %b want 0010", g); end
        vectors++; if (data_to_send !== 16'h1B1B) begin miscompares++; $display("FAIL wrap_first_data got %h want 1b1b", data_to_send); end
        req = 4'b1000;
        wait_grant(g);
        vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL wrap_second got %b want 1000", g); end
        vectors++; if (data_to_send !== 16'h3E3E) begin miscompares++; $display("FAIL wrap_second_data got %h want 3e3e", data_to_send); end
        req = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [N_REQ-1:0] g;
        int extra = 0;
        tx_len = 10;
        set_word(2, 16'hBEEF);
        req = 4'b0100;
        wait_grant(g);
        vectors++; if (g !== 4'b0100) begin miscompares++; $display("FAIL mid_grant got %b want 0100", g); end
        req = '0;
        for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk_9k6);
        repeat (2) @(negedge clk_9k6);
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL mid_sched_busy got %b want 0", sched_busy); end
        vectors++; if (data_to_send !== 16'h0000) begin miscompares++; $display("FAIL mid_data got %h want 0000", data_to_send); end
        vectors++; if (grant !== 4'b0000 || enable_transmiter !== 1'b0) begin miscompares++; $display("FAIL mid_pulses got grant %b enable %b want 0000 0", grant, enable_transmiter); end
        for (int i = 0; i < 30 && tx_busy; i++) @(negedge clk_9k6);
        @(negedge clk_9k6);
        set_word(0, 16'h0F0F);
        req = 4'b0001;
        rst_n = 1'b1;
        wait_grant(g);
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL mid_regrant got %b want 0001", g); end
        vectors++; if (data_to_send !== 16'h0F0F) begin miscompares++; $display("FAIL mid_regrant_data got %h want 0f0f", data_to_send); end
        req = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_9k6);
            if (grant !== 4'b0000) extra++;
            if (!sched_busy) break;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL mid_duplicate got %0d extra grants want 0", extra); end
        @(negedge clk_9k6);
    endtask

    task automatic test_timeout();
        logic [N_REQ-1:0] g;
        tx_stuck = 1'b1;
        set_word(1, 16'h7777);
        req = 4'b0010;
        wait_grant(g);
        vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL tmo_grant got %b want 0010", g); end
        req = '0;
        @(posedge clk_9k6);
        for (int i = 0; i <= 64; i++) begin
            @(negedge clk_9k6);
            if (i == 63) begin
                vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b want 0", err_timeout); end
            end
        end
`ifdef UART_SCHED_TIMEOUT_EN
        vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_flag got %b want 1", err_timeout); end
        tx_stuck = 1'b0;
        set_word(0, 16'h1234);
        req = 4'b0001;
        wait_grant(g);
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL tmo_next_grant got %b want 0001", g); end
        vectors++; if (data_to_send !== 16'h1234) begin miscompares++; $display("FAIL tmo_next_data got %h want 1234", data_to_send); end
        req = '0;
        wait_idle();
        vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %b want 1", err_timeout); end
`else
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_flag got %b want 0", err_timeout); end
        repeat (20) @(negedge clk_9k6);
        vectors++; if (sched_busy !== 1'b1) begin miscompares++; $display("FAIL tmo_stays_busy got %b want 1", sched_busy); end
        rst_n = 1'b0;
        @(negedge clk_9k6);
        vectors++; if (sched_busy !== 1'b0 || err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_recover got busy %b err %b want 0 0", sched_busy, err_timeout); end
        rst_n = 1'b1;
        tx_stuck = 1'b0;
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
